// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush sequencer for the 5-stage pipeline.
// Arbitrates halt, data-memory wait, mult/div handshake, taken branches and
// load-use hazards into per-stage register enables and flushes. It also keeps
// a saturating count of cycles in which the PC did not advance.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   loaduse, branch            registered hazard requests
//   md_req, md_done            mult/div request from EX, result-valid pulse
//   mem_wait, halt             data memory busy, halt retiring in WB
//   pc_en .. mem_wb_en         per-stage register enables (combinational)
//   if_id_flush .. ex_mem_flush  per-stage NOP insertion (combinational)
//   md_start                   one-cycle start pulse to mult/div (combinational)
//   md_err                     sticky mult/div timeout flag (registered)
//   stall_cnt                  saturating count of pc_en=0 cycles (registered)
module pipe_ctrl #(
  parameter int unsigned MD_MAX = 64,
  parameter int unsigned CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             loaduse,
  input  logic             branch,
  input  logic             md_req,
  input  logic             md_done,
  input  logic             mem_wait,
  input  logic             halt,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             md_start,
  output logic             md_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned MCW = (MD_MAX > 1) ? $clog2(MD_MAX) : 1;
  localparam logic [MCW-1:0] MD_LAST = MCW'(MD_MAX - 1);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_MD   = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [MCW-1:0] md_cnt;
  logic [MCW-1:0] md_cnt_nxt;
  logic           md_err_set;

  // State, mult/div wait counter, sticky error and stall counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_RUN;
      md_cnt    <= '0;
      md_err    <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state  <= state_nxt;
      md_cnt <= md_cnt_nxt;
      md_err <= md_err | md_err_set;
      if (!pc_en && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  // Next state and stage controls; one action per cycle in RUN by priority
  always_comb begin
    state_nxt    = state;
    md_cnt_nxt   = md_cnt;
    md_err_set   = 1'b0;
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    md_start     = 1'b0;

    case (state)
      S_RUN: begin
        if (halt) begin
          {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b0;
          state_nxt = S_HALT;
        end else if (mem_wait) begin
          {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b0;
        end else if (md_req) begin
          // Hold IF..EX on the mult/div, bubble into MEM, let WB drain
          md_start     = 1'b1;
          {pc_en, if_id_en, id_ex_en, ex_mem_en} = 4'b0;
          ex_mem_flush = 1'b1;
          md_cnt_nxt   = '0;
          state_nxt    = S_MD;
        end else if (branch) begin
          // Wrong-path instructions in IF/ID are squashed; loaduse is moot
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (loaduse) begin
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_flush = 1'b1;
        end
      end

      S_MD: begin
        // MEM/WB cannot advance while data memory is busy
        mem_wb_en = ~mem_wait;
        if (halt) begin
          {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b0;
          state_nxt = S_HALT;
        end else if (md_done || (md_cnt == MD_LAST)) begin
          // Result (or timeout) releases the pipeline this cycle
          md_err_set = ~md_done;
          state_nxt  = S_RUN;
        end else begin
          {pc_en, if_id_en, id_ex_en, ex_mem_en} = 4'b0;
          ex_mem_flush = 1'b1;
          md_cnt_nxt   = md_cnt + MCW'(1);
        end
      end

      S_HALT: begin
        {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b0;
      end

      default: begin
        state_nxt = S_RUN;
      end
    endcase
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios followed by random
// traffic, every cycle compared against a stage-freeze reference model.
module tb_pipe_ctrl;

  localparam int unsigned MD_MAX = 8;
  localparam int unsigned CNT_W  = 6;
  localparam longint SAT = (64'd1 << CNT_W) - 1;

  localparam int M_RUN  = 0;
  localparam int M_MD   = 1;
  localparam int M_HALT = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic loaduse, branch, md_req, md_done, mem_wait, halt;
  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic if_id_flush, id_ex_flush, ex_mem_flush, md_start, md_err;
  logic [CNT_W-1:0] stall_cnt;

  int checks = 0;
  int failures = 0;

  // Reference model state
  int     m_mode;
  int     m_waited;
  bit     m_err;
  longint m_stall;

  // Reference model per-cycle decision
  logic [4:0] e_en;     // {pc, if_id, id_ex, ex_mem, mem_wb}
  logic [2:0] e_fl;     // {if_id, id_ex, ex_mem}
  logic       e_start;
  int         e_mode_nxt;
  int         e_waited_nxt;
  bit         e_err_set;

  pipe_ctrl #(.MD_MAX(MD_MAX), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .loaduse(loaduse), .branch(branch), .md_req(md_req), .md_done(md_done),
    .mem_wait(mem_wait), .halt(halt),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush), .md_start(md_start), .md_err(md_err),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Enables with the first n stages (from IF side) frozen
  function automatic logic [4:0] freeze_front(input int n);
    logic [4:0] v;
    v = 5'b11111;
    for (int i = 0; i < n; i++) v[4-i] = 1'b0;
    return v;
  endfunction

  task automatic model_decide();
    e_en         = 5'b11111;
    e_fl         = 3'b000;
    e_start      = 1'b0;
    e_mode_nxt   = m_mode;
    e_waited_nxt = m_waited;
    e_err_set    = 1'b0;
    if (m_mode == M_HALT) begin
      e_en = freeze_front(5);
    end else if (m_mode == M_RUN) begin
      if (halt) begin
        e_en = freeze_front(5); e_mode_nxt = M_HALT;
      end else if (mem_wait) begin
        e_en = freeze_front(5);
      end else if (md_req) begin
        e_en = freeze_front(4); e_fl = 3'b001; e_start = 1'b1;
        e_mode_nxt = M_MD; e_waited_nxt = 0;
      end else if (branch) begin
        e_fl = 3'b110;
      end else if (loaduse) begin
        e_en = freeze_front(2); e_fl = 3'b010;
      end
    end else begin
      if (halt) begin
        e_en = freeze_front(5); e_mode_nxt = M_HALT;
      end else if (md_done || m_waited == int'(MD_MAX) - 1) begin
        e_err_set = !md_done;
        e_mode_nxt = M_RUN;
      end else begin
        e_en = freeze_front(4); e_fl = 3'b001;
        e_waited_nxt = m_waited + 1;
      end
      if (mem_wait) e_en[0] = 1'b0;
    end
  endtask

  // Caller sets inputs at the falling edge; check mid-low-phase, then advance
  task automatic tick();
    #2;
    model_decide();
    chk("stage_en", 64'({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}), 64'(e_en));
    chk("flush", 64'({if_id_flush, id_ex_flush, ex_mem_flush}), 64'(e_fl));
    chk("md_start", 64'(md_start), 64'(e_start));
    chk("md_err", 64'(md_err), 64'(m_err));
    chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
    @(posedge clk);
    if (!e_en[4] && m_stall < SAT) m_stall++;
    if (e_err_set) m_err = 1'b1;
    m_mode   = e_mode_nxt;
    m_waited = e_waited_nxt;
    @(negedge clk);
  endtask

  task automatic set_in(input logic lu, input logic br, input logic mr,
                        input logic md, input logic mw, input logic ht);
    loaduse = lu; branch = br; md_req = mr; md_done = md; mem_wait = mw; halt = ht;
  endtask

  task automatic do_reset();
    set_in(0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    m_mode = M_RUN; m_waited = 0; m_err = 1'b0; m_stall = 0;
    #2;
    chk("rst_en", 64'({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}), 64'h1f);
    chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    chk("rst_md_err", 64'(md_err), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    set_in(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    do_reset();

    // Idle after reset
    for (int i = 0; i < 10; i++) tick();

    // Single load-use bubble
    set_in(1, 0, 0, 0, 0, 0); tick();
    set_in(0, 0, 0, 0, 0, 0); tick();
    chk("loaduse_stall_cnt", 64'(stall_cnt), 64'd1);

    // Branch overrides loaduse
    set_in(1, 1, 0, 0, 0, 0); tick();
    set_in(0, 0, 0, 0, 0, 0); tick();
    chk("branch_no_stall", 64'(stall_cnt), 64'd1);

    // Mult/div with result after 5 wait cycles
    do_reset();
    set_in(0, 0, 1, 0, 0, 0); tick();
    for (int i = 0; i < 5; i++) tick();
    set_in(0, 0, 0, 1, 0, 0); tick();
    set_in(0, 0, 0, 0, 0, 0); tick();
    chk("md_stall_cnt", 64'(stall_cnt), 64'd6);
    chk("md_no_err", 64'(md_err), 64'd0);

    // Mult/div timeout, then memory freeze
    set_in(0, 0, 1, 0, 0, 0); tick();
    set_in(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < int'(MD_MAX); i++) tick();
    chk("md_timeout_err", 64'(md_err), 64'd1);
    set_in(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) tick();
    set_in(0, 0, 0, 0, 0, 0); tick();
    chk("md_err_sticky", 64'(md_err), 64'd1);

    // Halt during MD, counter saturation, reset out of HALT
    set_in(0, 0, 1, 0, 0, 0); tick();
    set_in(0, 0, 0, 0, 1, 0); tick();
    set_in(0, 0, 0, 0, 0, 1); tick();
    set_in(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 80; i++) tick();
    chk("halt_saturated", 64'(stall_cnt), 64'(SAT));
    do_reset();
    tick();
    chk("post_halt_pc_en", 64'(pc_en), 64'd1);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      set_in(($urandom % 4) == 0, ($urandom % 5) == 0, ($urandom % 4) == 0,
             ($urandom % 10) == 0, ($urandom % 7) == 0, ($urandom % 80) == 0);
      if ((m_mode == M_HALT && ($urandom % 8) == 0) || ($urandom % 150) == 0)
        do_reset();
      else
        tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central stall/flush sequencer for the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB). Consumes the registered hazard requests (LOADUSE, BRANCH) from the hazard unit, data-memory wait, and handshakes with the iterative mult/div unit. Drives per-stage register enables and flushes, plus a saturating stall-cycle counter for performance debug.

Parameters:
MD_MAX, 64, max cycles to wait for md_done before declaring a mult/div timeout
CNT_W, 32, width of stall_cnt

Ports:
clk  in  1  pipeline clock
rst_n  in  1  asynchronous active-low reset
loaduse  in  1  load-use hazard request (registered LOADUSE from hazard unit)
branch  in  1  taken branch/j/jr resolved in EX (registered BRANCH)
md_req  in  1  EX stage holds mult/div instruction
md_done  in  1  mult/div unit result valid (1-cycle pulse)
mem_wait  in  1  data memory not ready this cycle
halt  in  1  syscall/halt retiring in WB
pc_en  out  1  PC write enable
if_id_en  out  1  IF/ID register enable
id_ex_en  out  1  ID/EX register enable
ex_mem_en  out  1  EX/MEM register enable
mem_wb_en  out  1  MEM/WB register enable
if_id_flush  out  1  clear IF/ID to NOP
id_ex_flush  out  1  clear ID/EX to NOP
ex_mem_flush  out  1  clear EX/MEM to NOP
md_start  out  1  start pulse to mult/div unit
md_err  out  1  sticky mult/div timeout flag
stall_cnt  out  CNT_W  cycles with pc_en=0, saturating

Behaviour:
- Async reset (rst_n=0): state=RUN, md cycle counter=0, md_err=0, stall_cnt=0. Outputs are combinational from state+inputs; in RUN with all inputs 0: all *_en=1, all flushes=0, md_start=0.
- States: RUN, MD, HALT.
- RUN, priority halt > mem_wait > md_req > branch > loaduse (one action per cycle):
  - halt: all *_en=0, -> HALT.
  - mem_wait: all *_en=0, no flush, stay RUN (full freeze, repeats while mem_wait=1).
  - md_req: md_start=1 (exactly one cycle), pc_en/if_id_en/id_ex_en/ex_mem_en=0, ex_mem_flush=1, mem_wb_en=1; counter<=0; -> MD.
  - branch: all *_en=1, if_id_flush=1, id_ex_flush=1. Overrides simultaneous loaduse (wrong-path instruction).
  - loaduse: pc_en=0, if_id_en=0, id_ex_flush=1, others en=1. One bubble per asserted cycle.
- MD: pc_en/if_id_en/id_ex_en=0, ex_mem_flush=1, mem_wb_en=1, md_start=0; counter increments each cycle.
  - md_done=1: all *_en=1, no flush, -> RUN (result enters EX/MEM this cycle). md_req seen high in the following RUN cycle is the next instruction and restarts.
  - counter==MD_MAX-1 without md_done: md_err<=1 (sticky until reset), behave as md_done, -> RUN.
  - mem_wait in MD: ignored except mem_wb_en=0 while mem_wait=1.
  - halt in MD: -> HALT, all en=0.
- HALT: all *_en=0, flushes=0; left only by reset.
- stall_cnt: +1 on every clock edge where pc_en=0, holds at all-ones.
- Reset mid-MD or mid-HALT: immediate return to RUN values; md_start not re-issued until md_req seen in RUN.

Test Plan:
- Reset, idle inputs 10 cycles -> all *_en=1, flushes=0, stall_cnt=0, md_err=0.
- loaduse=1 for 1 cycle -> that cycle pc_en=0, if_id_en=0, id_ex_flush=1; next cycle all en=1; stall_cnt=1.
- branch=1 and loaduse=1 same cycle -> if_id_flush=id_ex_flush=1, pc_en=1, stall_cnt unchanged.
- md_req=1, md_done pulses 5 cycles after start -> md_start high 1 cycle, 5 stall cycles then release, stall_cnt=6, md_err=0.
- md_req=1, md_done never (MD_MAX=8) -> release after 8 MD cycles, md_err=1 stays high; mem_wait=1 for 3 cycles afterwards -> full freeze 3 cycles.
- halt=1 during MD -> HALT, all en=0 indefinitely; rst_n low mid-HALT -> RUN, stall_cnt=0.
